igbt_gate_monitor: RTL and testbench

IGBT_GATE_MONITOR -- requirements
Module: igbt_gate_monitor

---
 rtl/igbt_gate_monitor.sv | 166 ++++++++++++++++
 tb/tb_igbt_gate_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/igbt_gate_monitor.sv
// H-bridge gate monitor: synchronises and deglitches four IGBT gate drives, then checks them for
// shoot-through, dead-time and gate-active-while-stopped faults and latches the first one seen.
`timescale 1ns / 1ps
module igbt_gate_monitor #(
  parameter int unsigned FILT       = 3,
  parameter int unsigned DEAD_MIN   = 50,
  parameter int unsigned STOP_GRACE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RUDIN,
  input  logic       RDDIN,
  input  logic       LUDIN,
  input  logic       LDDIN,
  input  logic       start_stop,
  input  logic       err_clr,
  output logic       err_unit,
  output logic [2:0] err_code,
  output logic [1:0] igbt_state,
  output logic       state_valid
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned SW = (STOP_GRACE < 1) ? 1 : $clog2(STOP_GRACE + 1);

  // Gate bit order: 0 = RU, 1 = RD, 2 = LU, 3 = LD. Leg 0 = right, leg 1 = left.
  logic [3:0]    gate_raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] fcnt_q [4];
  logic [FW-1:0] fcnt_d [4];
  logic [7:0]    dcnt_q [2];
  logic [7:0]    dcnt_d [2];
  logic [1:0]    seen_q, seen_d;
  logic [SW-1:0] stop_q, stop_d;

  logic [3:0]    rise;
  logic [1:0]    leg_on, shoot, dead_viol;
  logic          stop_viol;
  logic [2:0]    fault_code;

  logic          err_unit_q, err_unit_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [1:0]    igbt_state_q, igbt_state_d;
  logic          state_valid_q, state_valid_d;

  assign gate_raw = {LDDIN, LUDIN, RDDIN, RUDIN};

  // Output follows the synchronised input only after FILT consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fcnt_d[i] = '0;
      filt_d[i] = filt_q[i];
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILT - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FW'(1);
        end
      end
    end
  end

  assign rise = filt_q & ~filt_prev_q;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      leg_on[l]    = filt_q[2*l] | filt_q[2*l+1];
      shoot[l]     = filt_q[2*l] & filt_q[2*l+1];
      // seen_q is still 0 on the very first turn-on of a leg, which exempts it.
      dead_viol[l] = (rise[2*l] | rise[2*l+1]) & seen_q[l] & (dcnt_q[l] < 8'(DEAD_MIN));
      dcnt_d[l]    = dcnt_q[l];
      if (leg_on[l]) begin
        dcnt_d[l] = '0;
      end else if (dcnt_q[l] < 8'(DEAD_MIN)) begin
        dcnt_d[l] = dcnt_q[l] + 8'd1;
      end
    end
    seen_d = seen_q | leg_on;
  end

  always_comb begin
    stop_d = stop_q;
    if (start_stop) begin
      stop_d = '0;
    end else if (stop_q != SW'(STOP_GRACE)) begin
      stop_d = stop_q + SW'(1);
    end
  end

  assign stop_viol = (stop_q == SW'(STOP_GRACE)) & (|filt_q);

  // Lowest code wins when several faults coincide.
  always_comb begin
    fault_code = 3'd0;
    if (shoot[0]) begin
      fault_code = 3'd1;
    end else if (shoot[1]) begin
      fault_code = 3'd2;
    end else if (dead_viol[0]) begin
      fault_code = 3'd3;
    end else if (dead_viol[1]) begin
      fault_code = 3'd4;
    end else if (stop_viol) begin
      fault_code = 3'd5;
    end
  end

  always_comb begin
    err_unit_d = err_unit_q;
    err_code_d = err_code_q;
    if (err_unit_q) begin
      if (err_clr && (fault_code == 3'd0)) begin
        err_unit_d = 1'b0;
        err_code_d = 3'd0;
      end
    end else if (fault_code != 3'd0) begin
      err_unit_d = 1'b1;
      err_code_d = fault_code;
    end
  end

  always_comb begin
    igbt_state_d  = igbt_state_q;
    state_valid_d = ~(|shoot);
    if (!(|shoot)) begin
      igbt_state_d = {filt_q[2], filt_q[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      filt_q        <= '0;
      filt_prev_q   <= '0;
      for (int i = 0; i < 4; i++) fcnt_q[i] <= '0;
      for (int l = 0; l < 2; l++) dcnt_q[l] <= '0;
      seen_q        <= '0;
      stop_q        <= '0;
      err_unit_q    <= 1'b0;
      err_code_q    <= 3'd0;
      igbt_state_q  <= 2'b00;
      state_valid_q <= 1'b1;
    end else begin
      sync1_q       <= gate_raw;
      sync2_q       <= sync1_q;
      filt_q        <= filt_d;
      filt_prev_q   <= filt_q;
      for (int i = 0; i < 4; i++) fcnt_q[i] <= fcnt_d[i];
      for (int l = 0; l < 2; l++) dcnt_q[l] <= dcnt_d[l];
      seen_q        <= seen_d;
      stop_q        <= stop_d;
      err_unit_q    <= err_unit_d;
      err_code_q    <= err_code_d;
      igbt_state_q  <= igbt_state_d;
      state_valid_q <= state_valid_d;
    end
  end

  assign err_unit    = err_unit_q;
  assign err_code    = err_code_q;
  assign igbt_state  = igbt_state_q;
  assign state_valid = state_valid_q;

endmodule

// File: tb/tb_igbt_gate_monitor.sv
// Self-checking bench for igbt_gate_monitor: a vector table driven through a scoreboard queue,
// followed by hand-written timing sequences for filter, shoot-through, stop and reset behaviour.
`timescale 1ns / 1ps
module tb_igbt_gate_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rudin = 1'b0, rddin = 1'b0, ludin = 1'b0, lddin = 1'b0;
  logic       start_stop = 1'b1;
  logic       err_clr = 1'b0;
  logic       err_unit;
  logic [2:0] err_code;
  logic [1:0] igbt_state;
  logic       state_valid;

  int checks = 0;
  int errors = 0;

  igbt_gate_monitor #(
    .FILT      (3),
    .DEAD_MIN  (50),
    .STOP_GRACE(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RUDIN      (rudin),
    .RDDIN      (rddin),
    .LUDIN      (ludin),
    .LDDIN      (lddin),
    .start_stop (start_stop),
    .err_clr    (err_clr),
    .err_unit   (err_unit),
    .err_code   (err_code),
    .igbt_state (igbt_state),
    .state_valid(state_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ru, rd, lu, ld, ss, clr;
    int         hold;
    logic       eu;
    logic [2:0] ec;
    logic [1:0] st;
    logic       sv;
  } vec_t;

  typedef struct packed {
    logic       eu;
    logic [2:0] ec;
    logic [1:0] st;
    logic       sv;
  } exp_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  exp_t exp_q [$];

  function automatic vec_t mk(logic ru, logic rd, logic lu, logic ld, logic ss, logic clr,
                              int hold, logic eu, logic [2:0] ec, logic [1:0] st, logic sv);
    vec_t v;
    v.ru = ru; v.rd = rd; v.lu = lu; v.ld = ld; v.ss = ss; v.clr = clr; v.hold = hold;
    v.eu = eu; v.ec = ec; v.st = st; v.sv = sv;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_gates(input logic ru, input logic rd, input logic lu, input logic ld);
    rudin = ru; rddin = rd; ludin = lu; lddin = ld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_gates(0, 0, 0, 0);
    start_stop = 1'b1;
    err_clr = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
  endtask

  task automatic check_outs(input string name, input logic eu, input logic [2:0] ec,
                            input logic [1:0] st, input logic sv);
    check({name, ".err_unit"}, 8'(err_unit), 8'(eu));
    check({name, ".err_code"}, 8'(err_code), 8'(ec));
    check({name, ".igbt_state"}, 8'(igbt_state), 8'(st));
    check({name, ".state_valid"}, 8'(state_valid), 8'(sv));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic ok;
    logic seen;

    //            ru rd lu ld ss clr hold  eu ec    st     sv
    tbl[0]  = mk(0, 0, 0, 0, 1, 0, 10,   0, 3'd0, 2'b00, 1);
    tbl[1]  = mk(1, 0, 0, 1, 1, 0, 10,   0, 3'd0, 2'b01, 1);  // first turn-on is exempt
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 60,   0, 3'd0, 2'b00, 1);
    tbl[3]  = mk(0, 1, 1, 0, 1, 0, 10,   0, 3'd0, 2'b10, 1);  // dead time honoured
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 60,   0, 3'd0, 2'b00, 1);
    tbl[5]  = mk(1, 0, 1, 0, 1, 0, 10,   0, 3'd0, 2'b11, 1);
    tbl[6]  = mk(1, 1, 1, 0, 1, 0, 10,   1, 3'd1, 2'b11, 0);  // shoot beats dead-time
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, 20,   1, 3'd1, 2'b00, 1);  // fault held
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 10,   0, 3'd0, 2'b00, 1);  // clear accepted
    tbl[9]  = mk(1, 0, 0, 0, 1, 0, 10,   1, 3'd3, 2'b01, 1);  // too soon after RD off
    tbl[10] = mk(1, 0, 0, 0, 1, 1, 10,   0, 3'd0, 2'b01, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 20,   1, 3'd5, 2'b01, 1);  // gate on while stopped
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 20,   1, 3'd5, 2'b00, 1);  // clear ignored: fault present
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 10,   0, 3'd0, 2'b00, 1);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, 10,   0, 3'd0, 2'b00, 1);

    wait_cyc(2);
    check_outs("reset", 0, 3'd0, 2'b00, 1);
    rst = 1'b0;
    wait_cyc(1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      set_gates(tbl[i].ru, tbl[i].rd, tbl[i].lu, tbl[i].ld);
      start_stop = tbl[i].ss;
      err_clr    = tbl[i].clr;
      e.eu = tbl[i].eu; e.ec = tbl[i].ec; e.st = tbl[i].st; e.sv = tbl[i].sv;
      exp_q.push_back(e);
      @(negedge clk);
      err_clr = 1'b0;
      wait_cyc(tbl[i].hold - 1);
      e = exp_q.pop_front();
      check_outs($sformatf("row%0d", i), e.eu, e.ec, e.st, e.sv);
    end

    // Filter latency: edge reaches igbt_state after 2 sync + FILT filter + 1 output register.
    do_reset();
    rudin = 1'b1;
    wait_cyc(5);
    check("latency_before", 8'(igbt_state), 8'(2'b00));
    wait_cyc(1);
    check("latency_exact", 8'(igbt_state), 8'(2'b01));

    // Two-cycle glitch on RD while RU is on must vanish.
    wait_cyc(5);
    rddin = 1'b1;
    wait_cyc(2);
    rddin = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (err_unit !== 1'b0 || state_valid !== 1'b1 || igbt_state !== 2'b01) ok = 1'b0;
    end
    check("glitch_ignored", 8'(ok), 8'(1));

    // A pulse of exactly FILT cycles on LU does get through.
    ludin = 1'b1;
    wait_cyc(3);
    ludin = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (igbt_state === 2'b11) seen = 1'b1;
    end
    check("filt_boundary_pass", 8'(seen), 8'(1));
    check("filt_boundary_noerr", 8'(err_unit), 8'(0));

    // Shoot-through timing, err_clr ignored during overlap, accepted after release.
    do_reset();
    rudin = 1'b1; rddin = 1'b1;
    wait_cyc(5);
    check("shoot_before", 8'(err_unit), 8'(0));
    wait_cyc(1);
    check_outs("shoot_exact", 1, 3'd1, 2'b00, 0);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    check("shoot_clr_ignored.eu", 8'(err_unit), 8'(1));
    check("shoot_clr_ignored.ec", 8'(err_code), 8'(3'd1));
    wait_cyc(3);
    rudin = 1'b0; rddin = 1'b0;
    wait_cyc(8);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    check_outs("shoot_cleared", 0, 3'd0, 2'b00, 1);

    // Dead-time violation on both legs in the same cycle: right leg's code wins.
    do_reset();
    rudin = 1'b1; ludin = 1'b1;
    wait_cyc(10);
    check("dead_first_exempt", 8'(err_unit), 8'(0));
    rudin = 1'b0; ludin = 1'b0;
    wait_cyc(20);
    rddin = 1'b1; lddin = 1'b1;
    wait_cyc(10);
    check("dead_both.eu", 8'(err_unit), 8'(1));
    check("dead_both.ec", 8'(err_code), 8'(3'd3));

    // Stop fault STOP_GRACE+1 cycles after start_stop falls.
    do_reset();
    ludin = 1'b1;
    wait_cyc(10);
    start_stop = 1'b0;
    wait_cyc(8);
    check("stop_before", 8'(err_unit), 8'(0));
    wait_cyc(1);
    check("stop_exact.eu", 8'(err_unit), 8'(1));
    check("stop_exact.ec", 8'(err_code), 8'(3'd5));

    // Gate dropped early enough after stop: no fault.
    do_reset();
    ludin = 1'b1;
    wait_cyc(10);
    start_stop = 1'b0;
    wait_cyc(3);
    ludin = 1'b0;
    wait_cyc(20);
    check("stop_drop.eu", 8'(err_unit), 8'(0));
    check("stop_drop.ec", 8'(err_code), 8'(3'd0));

    // Reset mid-fault clears outputs asynchronously; next turn-on is exempt.
    do_reset();
    rudin = 1'b1; rddin = 1'b1;
    wait_cyc(10);
    check("pre_rst_fault", 8'(err_unit), 8'(1));
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 0, 3'd0, 2'b00, 1);
    set_gates(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(1);
    rddin = 1'b1;
    wait_cyc(10);
    check("post_rst_exempt", 8'(err_unit), 8'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
